// File: rtl/laser_setup_pkg.sv
// rtl/laser_setup_pkg.sv - shared state encoding, step index width and setup word table
package laser_setup_pkg;

  localparam int STEP_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_SETTLE,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  // Index 0 is the leftmost word; unused tail entries are no-op writes.
  localparam logic [0:15][15:0] SETUP_TABLE = {
    16'h8001,  // DAC soft reset
    16'h9010,  // internal reference select
    16'hA001,  // power up X channel
    16'hA002,  // power up Y channel
    16'h3800,  // zero X output
    16'h3900,  // zero Y output
    16'hC0A0,  // laser driver bias
    16'hD001,  // laser driver enable
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/seq_delay_counter.sv
// rtl/seq_delay_counter.sv - loadable saturating down-counter with a zero flag
module seq_delay_counter #(
  parameter int CNT_W      = 8,
  // 1: flag reports the value the counter is about to take (look-ahead zero)
  parameter bit EARLY_ZERO = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = EARLY_ZERO ? (count_d == '0) : (count_q == '0);

endmodule

// File: rtl/dac_setup_sequencer.sv
// rtl/dac_setup_sequencer.sv - DAC setup word sequencer with settle delay and ack timeout; SETUP_RETRY_EN adds one retry per step
module dac_setup_sequencer
  import laser_setup_pkg::*;
#(
  parameter int NUM_STEPS      = 8,
  parameter int DATA_W         = 16,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  setup_start,
  output logic                  wr_req,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_ack,
  output logic                  busy,
  output logic                  setup_done,
  output logic                  setup_error,
  output logic [STEP_IDX_W-1:0] step_idx
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [STEP_IDX_W-1:0] LAST_STEP = STEP_IDX_W'(NUM_STEPS - 1);

  function automatic logic [DATA_W-1:0] table_word(input logic [STEP_IDX_W-1:0] idx);
    return DATA_W'(SETUP_TABLE[idx]);
  endfunction

  seq_state_e             state_q, state_d;
  logic [STEP_IDX_W-1:0]  step_q, step_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   wr_req_q, wr_req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef SETUP_RETRY_EN
  logic                   retry_q, retry_d;
`endif

  logic tmo_load, tmo_dec, tmo_expire;
  logic set_load, set_dec, settle_zero;

  // Counter controls come from registered state only, so no loop through the FSM.
  assign tmo_load = (state_q == ST_ISSUE);
  assign tmo_dec  = (state_q == ST_WAIT_ACK) && !wr_ack;
  assign set_load = (state_q == ST_WAIT_ACK) && wr_ack;
  assign set_dec  = (state_q == ST_SETTLE);

  // Look-ahead zero: expiry is seen on the edge the count would reach 0.
  seq_delay_counter #(.CNT_W(CNT_W), .EARLY_ZERO(1'b1)) u_timeout (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (tmo_load),
    .load_val_i (CNT_W'(TIMEOUT_CYCLES)),
    .dec_i      (tmo_dec),
    .zero_o     (tmo_expire)
  );

  seq_delay_counter #(.CNT_W(CNT_W), .EARLY_ZERO(1'b0)) u_settle (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (set_load),
    .load_val_i (CNT_W'(SETTLE_CYCLES)),
    .dec_i      (set_dec),
    .zero_o     (settle_zero)
  );

  // Next-state and next-output logic; outputs derive from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef SETUP_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (setup_start) begin
          step_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef SETUP_RETRY_EN
          retry_d = 1'b0;
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wr_data_d = table_word(step_q);
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wr_ack) begin
`ifdef SETUP_RETRY_EN
          retry_d = 1'b0;
`endif
          state_d = ST_SETTLE;
        end else if (tmo_expire) begin
`ifdef SETUP_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
`else
          err_d   = 1'b1;
          state_d = ST_ERROR;
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_zero) begin
          if (step_q == LAST_STEP) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + STEP_IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wr_req_d = (state_d == ST_WAIT_ACK);
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK) || (state_d == ST_SETTLE);
  end

  // State and output registers; reset aborts any pending write immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      wr_data_q <= '0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SETUP_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      wr_data_q <= wr_data_d;
      wr_req_q  <= wr_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SETUP_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign wr_req      = wr_req_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign setup_done  = done_q;
  assign setup_error = err_q;
  assign step_idx    = step_q;

endmodule
